// File: rtl/matrix_pkg.sv
// Shared types and helpers for the matrix loader: FSM state encoding,
// default element width and row-major flat index.
package matrix_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } ld_state_e;

  localparam int ELEM_W = 32;

  function automatic int flat_idx(input int i, input int j, input int n);
    return i * n + j;
  endfunction

endpackage

// File: rtl/mat_idx_counter.sv
// Element index for the loader: increments per accept, wraps to zero after
// the last element of an N x N matrix, synchronous clear has priority.
module mat_idx_counter #(
  parameter int N  = 2,
  parameter int IW = (N * N > 1) ? $clog2(N * N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  output logic [IW-1:0] idx,
  output logic          last
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N * N - 1);

  logic [IW-1:0] idx_q, idx_d;

  assign idx  = idx_q;
  assign last = (idx_q == LAST_IDX);

  always_comb begin
    idx_d = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (inc) begin
      idx_d = last ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idx_q <= '0;
    else     idx_q <= idx_d;
  end

endmodule

// File: rtl/matrix_loader.sv
// Streams A then B (row-major) into two N x N register matrices and holds the pair
// for a multiplier. MATRIX_LOADER_TRANSPOSE_B_EN: B is streamed column-major.
module matrix_loader
  import matrix_pkg::*;
#(
  parameter int N = 2,
  parameter int W = ELEM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic [N*N*W-1:0] mat_a,
  output logic [N*N*W-1:0] mat_b,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int IW = (N * N > 1) ? $clog2(N * N) : 1;

  ld_state_e     state_q, state_d;
  logic [IW-1:0] idx;
  logic [IW-1:0] b_idx;
  logic          idx_last;
  logic          accept;
  logic          inc;
  logic          wr_a, wr_b;
  logic [W-1:0]  a_q [N*N];
  logic [W-1:0]  b_q [N*N];

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;
  assign wr_a      = accept && !clear && (state_q == LOAD_A);
  assign wr_b      = accept && !clear && (state_q == LOAD_B);

  mat_idx_counter #(.N(N), .IW(IW)) u_idx (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (inc),
    .idx   (idx),
    .last  (idx_last)
  );

  always_comb begin
    b_idx = idx;
`ifdef MATRIX_LOADER_TRANSPOSE_B_EN
    // stream position k = r*N + c lands at element (c, r)
    b_idx = IW'(flat_idx(int'(idx) % N, int'(idx) / N, N));
`endif
  end

  always_comb begin
    state_d = state_q;
    inc     = 1'b0;
    case (state_q)
      LOAD_A: if (accept) begin
        inc = 1'b1;
        if (idx_last) state_d = LOAD_B;
      end
      LOAD_B: if (accept) begin
        inc = 1'b1;
        if (idx_last) state_d = HOLD;
      end
      HOLD:    if (out_ready) state_d = LOAD_A;
      default: state_d = LOAD_A;
    endcase
    if (clear) begin
      state_d = LOAD_A;
      inc     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LOAD_A;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N * N; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else begin
      if (wr_a) a_q[idx]   <= in_data;
      if (wr_b) b_q[b_idx] <= in_data;
    end
  end

  for (genvar k = 0; k < N * N; k++) begin : g_flat
    assign mat_a[k*W +: W] = a_q[k];
    assign mat_b[k*W +: W] = b_q[k];
  end

endmodule
